change_dispenser: RTL
=====================

// Module: change_dispenser
// PURPOSE
//  Downstream stage of vending_machine: takes the change amount the vending machine owes and pays it out as coins.
//  Drives one coin-eject solenoid per pulse from three coin tubes (10c, 20c, 50c).
//  Pays greedily, tracks tube inventory, and reports any amount it cannot pay.
//  Single clock domain; reset is synchronous and active-high.
// PARAMETERS
//  AMT_W        8  width of amount / remainder in cents (max 255c)
//  EJECT_CYCLES 2  eject pulse width in clk cycles, >=1
//  GAP_CYCLES   1  idle cycles between ejects, >=1
//  INIT_10C     8  10c tube count after reset / refill
//  INIT_20C     8  20c tube count after reset / refill
//  INIT_50C     4  50c tube count after reset / refill
// PORTS
//  clk         in   1      system clock, rising edge
//  reset       in   1      synchronous, active-high
//  req_valid   in   1      change request present
//  req_ready   out  1      block can accept a request (high only in IDLE)
//  req_amount  in   AMT_W  change owed in cents, sampled on accept
//  refill      in   1      reload all tubes to INIT_* (honoured in IDLE only)
//  eject       out  1      solenoid drive, high for EJECT_CYCLES per coin
//  eject_coin  out  2      coin being ejected: 00=10c 01=20c 10=50c (11 unused); valid while eject=1
//  busy        out  1      request in progress (any state but IDLE)
//  done        out  1      1-cycle pulse when payout finishes
//  short       out  1      1-cycle pulse with done when remainder != 0
//  remainder   out  AMT_W  unpaid cents, held from done until next accept
//  cnt_10c     out  8      10c tube inventory
//  cnt_20c     out  8      20c tube inventory
//  cnt_50c     out  8      50c tube inventory
// BEHAVIOUR
//  Reset values:
//   - state=IDLE; req_ready=1.
//   - eject, eject_coin, busy, done, short, remainder = 0.
//   - cnt_* = INIT_*.
//   - Reset mid-payout aborts immediately; the coin pulse in flight is cut.
//  Accept: req_valid & req_ready at edge N.
//   - rem <= req_amount rounded down to a multiple of 10.
//   - The sub-10 residue (req_amount % 10) is pre-loaded into remainder.
//  FSM:
//   - IDLE -> PICK on accept; refill in the same cycle as accept is ignored.
//   - PICK (1 cycle): choose the largest coin c in {50,20,10} with c <= rem and cnt_c > 0.
//     - If found: cnt_c -= 1, rem -= c, go to EJECT.
//     - If rem == 0 or no coin fits: go to DONE.
//   - EJECT: eject=1 with eject_coin stable for EJECT_CYCLES, then GAP.
//   - GAP: eject=0 for GAP_CYCLES, then PICK.
//   - DONE (1 cycle): done=1; remainder += rem; short = (remainder != 0); then IDLE.
//  Latency:
//   - First eject rises at edge N+2.
//   - Each coin costs 1 + EJECT_CYCLES + GAP_CYCLES cycles.
//   - Amount 0: done at edge N+2 with no eject.
//  Boundaries:
//   - Greedy is the decided algorithm; it does not backtrack. Example: 60c with no 10c tube pays 50c, then short with remainder 10.
//   - A tube at 0 is never ejected and never decremented below 0.
//   - req_valid while busy is ignored; the requester holds it until ready.
//   - refill while busy is ignored, not queued.
//   - Inventory counters saturate at 0 and are 8 bits; INIT_* must be <= 255.
//   - remainder width AMT_W; the sum cannot exceed req_amount.
// STRUCTURE
//  vm_defs.vh, shared with vending_machine:
//   - Coin codes COIN_10C=2'b00, COIN_20C=2'b01, COIN_50C=2'b10.
//   - Coin values in cents.
//   - Change FSM state encodings.
//  Sub-module pulse_timer: loadable down-counter with a zero flag, used for both EJECT and GAP timing.
//  Tube counters, rem register and FSM live in change_dispenser.
// TESTING (defaults; clk period 10)
//  1. Reset, then req 80c -> ejects 50c, 20c, 10c (3 pulses, each 2 cycles wide); done, short=0; cnts 7/7/3.
//  2. Req 0c -> no eject; done pulse 2 cycles after accept; remainder 0.
//  3. Req 35c -> pays 20c + 10c; done with short=1, remainder 5.
//  4. Drain 10c tube (8x req 10c), then req 60c -> pays 50c only; short=1, remainder 10, cnt_10c stays 0.
//  5. Req 100c, assert reset after the first eject -> all outputs 0 next cycle; cnts back to 8/8/4; req_ready=1.
//  6. req_valid and refill held during payout -> second request accepted only after done; refill has no effect until IDLE.

Source files
------------

// File: rtl/change_dispenser_pkg.sv
// Shared coin codes, coin values and payout FSM states
// for the change dispenser and its timer.
package change_dispenser_pkg;

  localparam logic [1:0] COIN_10C = 2'b00;
  localparam logic [1:0] COIN_20C = 2'b01;
  localparam logic [1:0] COIN_50C = 2'b10;

  localparam int VAL_10C = 10;
  localparam int VAL_20C = 20;
  localparam int VAL_50C = 50;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PICK,
    ST_EJECT,
    ST_GAP,
    ST_DONE
  } chg_state_e;

endpackage

// File: rtl/change_dispenser_timer.sv
// Loadable down-counter with zero flag; times eject and gap.
// Ports: clk, reset, load_i, val_i, zero_o.
module change_dispenser_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load_i,
  input  logic [W-1:0] val_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= val_i;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/change_dispenser.sv
// Greedy coin payout from 10c/20c/50c tubes with inventory.
// Ports: request handshake, refill, eject drive, status, counts.
module change_dispenser
  import change_dispenser_pkg::*;
#(
  parameter int AMT_W        = 8,
  parameter int EJECT_CYCLES = 2,
  parameter int GAP_CYCLES   = 1,
  parameter int INIT_10C     = 8,
  parameter int INIT_20C     = 8,
  parameter int INIT_50C     = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [AMT_W-1:0] req_amount,
  input  logic             refill,
  output logic             eject,
  output logic [1:0]       eject_coin,
  output logic             busy,
  output logic             done,
  output logic             short,
  output logic [AMT_W-1:0] remainder,
  output logic [7:0]       cnt_10c,
  output logic [7:0]       cnt_20c,
  output logic [7:0]       cnt_50c
);

  localparam int TMR_W = 8;
  localparam logic [AMT_W-1:0] V10 = AMT_W'(VAL_10C);
  localparam logic [AMT_W-1:0] V20 = AMT_W'(VAL_20C);
  localparam logic [AMT_W-1:0] V50 = AMT_W'(VAL_50C);

  chg_state_e       state_q, state_d;
  logic [AMT_W-1:0] rem_q, rem_d;
  logic [AMT_W-1:0] remainder_q, remainder_d;
  logic [1:0]       coin_q, coin_d;
  logic [7:0]       c10_q, c10_d;
  logic [7:0]       c20_q, c20_d;
  logic [7:0]       c50_q, c50_d;
  logic             eject_q, eject_d;
  logic [1:0]       ecoin_q, ecoin_d;
  logic             done_q, done_d;
  logic             short_q, short_d;

  logic             tmr_load;
  logic [TMR_W-1:0] tmr_val;
  logic             tmr_zero;

  logic [AMT_W-1:0] resid;
  logic             fit50, fit20, fit10;
  logic             take50, take20, take10;

  assign resid = req_amount % V10;

  assign fit50 = (rem_q >= V50) && (c50_q != 8'd0);
  assign fit20 = (rem_q >= V20) && (c20_q != 8'd0);
  assign fit10 = (rem_q >= V10) && (c10_q != 8'd0);

  // One-hot greedy choice, largest coin first
  assign take50 = fit50;
  assign take20 = !fit50 && fit20;
  assign take10 = !fit50 && !fit20 && fit10;

  change_dispenser_timer #(.W(TMR_W)) u_tmr (
    .clk    (clk),
    .reset  (reset),
    .load_i (tmr_load),
    .val_i  (tmr_val),
    .zero_o (tmr_zero)
  );

  always_comb begin
    state_d     = state_q;
    rem_d       = rem_q;
    remainder_d = remainder_q;
    coin_d      = coin_q;
    c10_d       = c10_q;
    c20_d       = c20_q;
    c50_d       = c50_q;
    tmr_load    = 1'b0;
    tmr_val     = '0;
    done_d      = 1'b0;
    short_d     = 1'b0;
    // Outputs are registered from the current state
    eject_d     = (state_q == ST_EJECT);
    ecoin_d     = eject_d ? coin_q : 2'b00;

    unique case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          state_d     = ST_PICK;
          rem_d       = req_amount - resid;
          remainder_d = resid;
        end else if (refill) begin
          c10_d = 8'(INIT_10C);
          c20_d = 8'(INIT_20C);
          c50_d = 8'(INIT_50C);
        end
      end
      ST_PICK: begin
        state_d  = ST_EJECT;
        tmr_load = 1'b1;
        tmr_val  = TMR_W'(EJECT_CYCLES - 1);
        unique case (1'b1)
          take50: begin
            c50_d  = c50_q - 8'd1;
            rem_d  = rem_q - V50;
            coin_d = COIN_50C;
          end
          take20: begin
            c20_d  = c20_q - 8'd1;
            rem_d  = rem_q - V20;
            coin_d = COIN_20C;
          end
          take10: begin
            c10_d  = c10_q - 8'd1;
            rem_d  = rem_q - V10;
            coin_d = COIN_10C;
          end
          default: begin
            state_d  = ST_DONE;
            tmr_load = 1'b0;
          end
        endcase
      end
      ST_EJECT: begin
        if (tmr_zero) begin
          state_d  = ST_GAP;
          tmr_load = 1'b1;
          tmr_val  = TMR_W'(GAP_CYCLES - 1);
        end
      end
      ST_GAP: begin
        if (tmr_zero) state_d = ST_PICK;
      end
      ST_DONE: begin
        remainder_d = remainder_q + rem_q;
        done_d      = 1'b1;
        short_d     = (remainder_d != '0);
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      rem_q       <= '0;
      remainder_q <= '0;
      coin_q      <= 2'b00;
      c10_q       <= 8'(INIT_10C);
      c20_q       <= 8'(INIT_20C);
      c50_q       <= 8'(INIT_50C);
      eject_q     <= 1'b0;
      ecoin_q     <= 2'b00;
      done_q      <= 1'b0;
      short_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      remainder_q <= remainder_d;
      coin_q      <= coin_d;
      c10_q       <= c10_d;
      c20_q       <= c20_d;
      c50_q       <= c50_d;
      eject_q     <= eject_d;
      ecoin_q     <= ecoin_d;
      done_q      <= done_d;
      short_q     <= short_d;
    end
  end

  assign req_ready  = (state_q == ST_IDLE);
  assign busy       = (state_q != ST_IDLE);
  assign eject      = eject_q;
  assign eject_coin = ecoin_q;
  assign done       = done_q;
  assign short      = short_q;
  assign remainder  = remainder_q;
  assign cnt_10c    = c10_q;
  assign cnt_20c    = c20_q;
  assign cnt_50c    = c50_q;

endmodule
